dso_capture_ctrl: RTL and testbench

Sequences sample-RAM writes for the DSO acquisition path: generates the write-enable and circular write address for the capture RAM, enforces a pre-trigger fill, waits for the trigger, then counts a programmable post-trigger run and stops. Sits between the ADC sample strobe/trigger comparator and the capture RAM. A NIOS2 Avalon-MM slave port arms, aborts and reads back status, trigger address and the completion interrupt. It replaces software toggling of the RAM write-enable.

---
 rtl/dso_capture_pkg.sv | 25 ++
 rtl/dso_capture_regs.sv | 82 ++++++++
 rtl/dso_capture_ctrl.sv | 107 ++++++++++
 tb/tb_dso_capture_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_capture_pkg.sv
// Shared definitions for the DSO capture controller: state codes, register map
// offsets and CTRL/STATUS bit positions.
package dso_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_PRE     = 3'd2;
  localparam logic [2:0] REG_POST    = 3'd3;
  localparam logic [2:0] REG_TRIG    = 3'd4;
  localparam logic [2:0] REG_WR_ADDR = 3'd5;

  localparam int CTRL_ARM_BIT    = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int STATUS_DONE_BIT = 3;

endpackage

// File: rtl/dso_capture_regs.sv
// Avalon-MM slave register file for the capture controller: write decode,
// ARM/ABORT pulses, DONE flag with write-one-to-clear, irq and readdata mux.
module dso_capture_regs
  import dso_capture_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [2:0]        state_code,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              done_set,
  output logic              arm,
  output logic              abort,
  output logic [ADDR_W-1:0] pre_count,
  output logic [ADDR_W-1:0] post_count,
  output logic              irq
);

  logic wr_en;
  logic ctrl_wr;
  logic done_w1c;
  logic irq_en;
  logic done_flag;
  logic unused_wdata;

  assign wr_en    = chipselect && !write_n;
  assign ctrl_wr  = wr_en && (address == REG_CTRL);
  assign abort    = ctrl_wr && writedata[CTRL_ABORT_BIT];
  // ABORT takes priority, so an ARM sharing the write has no effect at all.
  assign arm      = ctrl_wr && writedata[CTRL_ARM_BIT] && !writedata[CTRL_ABORT_BIT];
  assign done_w1c = wr_en && (address == REG_STATUS) && writedata[STATUS_DONE_BIT];

  // Upper write-data bits have no register behind them.
  assign unused_wdata = ^writedata[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en     <= 1'b0;
      pre_count  <= '0;
      post_count <= '0;
      done_flag  <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (ctrl_wr)
        irq_en <= writedata[CTRL_IRQ_EN_BIT];
      if (wr_en && (address == REG_PRE))
        pre_count <= writedata[ADDR_W-1:0];
      if (wr_en && (address == REG_POST))
        post_count <= writedata[ADDR_W-1:0];
      // Completion outranks a same-cycle clear so the event is never lost.
      if (done_set)
        done_flag <= 1'b1;
      else if (arm || done_w1c)
        done_flag <= 1'b0;
      irq <= done_flag && irq_en;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL:    readdata[CTRL_IRQ_EN_BIT] = irq_en;
      REG_STATUS: begin
        readdata[2:0]             = state_code;
        readdata[STATUS_DONE_BIT] = done_flag;
      end
      REG_PRE:     readdata[ADDR_W-1:0] = pre_count;
      REG_POST:    readdata[ADDR_W-1:0] = post_count;
      REG_TRIG:    readdata[ADDR_W-1:0] = trig_addr;
      REG_WR_ADDR: readdata[ADDR_W-1:0] = wr_addr;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: rtl/dso_capture_ctrl.sv
// DSO capture sequencer: pre-trigger fill, trigger wait, post-trigger count,
// driving the capture RAM write enable and circular write address.
module dso_capture_ctrl
  import dso_capture_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              sample_en,
  input  logic              trig_in,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic              irq
);

  cap_state_e        state_q;
  cap_state_e        state_d;
  logic              arm;
  logic              abort;
  logic              done_set;
  logic              trig_take;
  logic [ADDR_W-1:0] pre_count;
  logic [ADDR_W-1:0] post_count;
  logic [ADDR_W-1:0] pre_cnt_q;
  logic [ADDR_W-1:0] post_cnt_q;
  logic [ADDR_W-1:0] pre_cnt_inc;
  logic [ADDR_W-1:0] post_cnt_inc;
  logic [ADDR_W-1:0] trig_addr_q;

  dso_capture_regs #(.ADDR_W(ADDR_W)) u_regs (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .state_code (state_q),
    .trig_addr  (trig_addr_q),
    .wr_addr    (ram_wraddr),
    .done_set   (done_set),
    .arm        (arm),
    .abort      (abort),
    .pre_count  (pre_count),
    .post_count (post_count),
    .irq        (irq)
  );

  // Reset gates the write enable so a reset mid-capture stops writes at once.
  assign ram_wren = sample_en && !reset &&
                    (state_q inside {ST_PRE, ST_ARMED, ST_POST});

  assign pre_cnt_inc  = pre_cnt_q + ADDR_W'(1);
  assign post_cnt_inc = post_cnt_q + ADDR_W'(1);
  assign trig_take    = ram_wren && (state_q == ST_ARMED) && trig_in && !arm && !abort;

  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d = (pre_count == '0) ? ST_ARMED : ST_PRE;
    end else if (ram_wren) begin
      case (state_q)
        ST_PRE:   if (pre_cnt_inc >= pre_count) state_d = ST_ARMED;
        ST_ARMED: if (trig_in) state_d = (post_count == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (post_cnt_inc >= post_count) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
    done_set = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ram_wraddr  <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        ram_wraddr <= '0;
        pre_cnt_q  <= '0;
        post_cnt_q <= '0;
      end else begin
        if (ram_wren)
          ram_wraddr <= ram_wraddr + ADDR_W'(1);
        if (ram_wren && (state_q == ST_PRE))
          pre_cnt_q <= pre_cnt_inc;
        if (ram_wren && (state_q == ST_POST))
          post_cnt_q <= post_cnt_inc;
      end
      if (trig_take)
        trig_addr_q <= ram_wraddr;
    end
  end

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Self-checking bench for dso_capture_ctrl: expected RAM write addresses are
// queued as samples are driven and checked as the DUT asserts ram_wren.
module tb_dso_capture_ctrl;

  localparam int AW = 4;

  logic          clk;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          sample_en;
  logic          trig_in;
  logic          ram_wren;
  logic [AW-1:0] ram_wraddr;
  logic          irq;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_exp;
  logic [31:0]   rd;

  dso_capture_ctrl #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sample_en  (sample_en),
    .trig_in    (trig_in),
    .ram_wren   (ram_wren),
    .ram_wraddr (ram_wraddr),
    .irq        (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always begin
    @(negedge clk);
    #3;
    if (ram_wren === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: wrote addr %0d, required no write", ram_wraddr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (ram_wraddr !== mon_exp)
          $display("FAIL write_addr: got %0d, required %0d", ram_wraddr, mon_exp);
        else
          pass_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic avl_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic avl_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
  endtask

  // Reads within the current cycle; used right after a write returns.
  task automatic peek(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1 d = readdata;
  endtask

  task automatic drive_sample(input logic trig, input logic exp_wr, input logic [AW-1:0] exp_addr);
    @(negedge clk);
    if (exp_wr) exp_q.push_back(exp_addr);
    sample_en = 1'b1; trig_in = trig;
    @(negedge clk);
    sample_en = 1'b0; trig_in = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      avl_read(3'(a), rd);
      total_cnt++;
      if (rd !== 32'd0) $display("FAIL reset_reg%0d: got %0h, required 0", a, rd);
      else pass_cnt++;
    end
    total_cnt++;
    if (irq !== 1'b0 || ram_wraddr !== '0)
      $display("FAIL reset_outputs: irq %0b wraddr %0d, required 0 0", irq, ram_wraddr);
    else pass_cnt++;
    repeat (3) drive_sample(1'b1, 1'b0, '0);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL reset_sb: %0d writes missing, required 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_full_capture;
    avl_write(3'd2, 32'd4);
    avl_write(3'd3, 32'd3);
    avl_write(3'd0, 32'h5);
    for (int i = 0; i < 9; i++) drive_sample(i == 5, 1'b1, AW'(i));
    peek(3'd1, rd);
    total_cnt++;
    if (rd !== 32'hC) $display("FAIL full_status: got %0h, required c", rd);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL full_irq_early: got %0b, required 0", irq);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL full_irq: got %0b, required 1", irq);
    else pass_cnt++;
    repeat (2) drive_sample(1'b0, 1'b0, '0);
    avl_read(3'd4, rd);
    total_cnt++;
    if (rd !== 32'd5) $display("FAIL full_trig_addr: got %0d, required 5", rd);
    else pass_cnt++;
    avl_read(3'd5, rd);
    total_cnt++;
    if (rd !== 32'd9) $display("FAIL full_wr_addr: got %0d, required 9", rd);
    else pass_cnt++;
    avl_read(3'd0, rd);
    total_cnt++;
    if (rd !== 32'h4) $display("FAIL full_ctrl: got %0h, required 4", rd);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL full_sb: %0d writes missing, required 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_zero_counts;
    avl_write(3'd2, 32'd0);
    avl_write(3'd3, 32'd0);
    avl_write(3'd0, 32'h5);
    peek(3'd1, rd);
    total_cnt++;
    if (rd !== 32'h2) $display("FAIL zero_armed: got %0h, required 2", rd);
    else pass_cnt++;
    drive_sample(1'b1, 1'b1, AW'(0));
    peek(3'd1, rd);
    total_cnt++;
    if (rd !== 32'hC) $display("FAIL zero_done: got %0h, required c", rd);
    else pass_cnt++;
    repeat (2) drive_sample(1'b1, 1'b0, '0);
    avl_read(3'd4, rd);
    total_cnt++;
    if (rd !== 32'd0) $display("FAIL zero_trig_addr: got %0d, required 0", rd);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL zero_sb: %0d writes missing, required 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_wrap;
    avl_write(3'd2, 32'd2);
    avl_write(3'd3, 32'd0);
    avl_write(3'd0, 32'h5);
    for (int i = 0; i < 20; i++) drive_sample(i == 0, 1'b1, AW'(i));
    peek(3'd1, rd);
    total_cnt++;
    if (rd !== 32'h2) $display("FAIL wrap_armed: got %0h, required 2", rd);
    else pass_cnt++;
    drive_sample(1'b1, 1'b1, AW'(4));
    avl_read(3'd4, rd);
    total_cnt++;
    if (rd !== 32'd4) $display("FAIL wrap_trig_addr: got %0d, required 4", rd);
    else pass_cnt++;
    avl_read(3'd1, rd);
    total_cnt++;
    if (rd !== 32'hC) $display("FAIL wrap_done: got %0h, required c", rd);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL wrap_sb: %0d writes missing, required 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_abort_priority;
    avl_write(3'd2, 32'd1);
    avl_write(3'd3, 32'd5);
    avl_write(3'd0, 32'h5);
    drive_sample(1'b0, 1'b1, AW'(0));
    drive_sample(1'b1, 1'b1, AW'(1));
    drive_sample(1'b0, 1'b1, AW'(2));
    peek(3'd1, rd);
    total_cnt++;
    if (rd !== 32'h3) $display("FAIL abort_in_post: got %0h, required 3", rd);
    else pass_cnt++;
    avl_write(3'd0, 32'h6);
    peek(3'd1, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL abort_idle: got %0h, required 0", rd);
    else pass_cnt++;
    repeat (2) drive_sample(1'b1, 1'b0, '0);
    avl_read(3'd5, rd);
    total_cnt++;
    if (rd !== 32'd3) $display("FAIL abort_wr_addr: got %0d, required 3", rd);
    else pass_cnt++;
    // ARM together with ABORT from ARMED
    avl_write(3'd2, 32'd0);
    avl_write(3'd0, 32'h5);
    avl_write(3'd0, 32'h7);
    peek(3'd1, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL arm_abort_idle: got %0h, required 0", rd);
    else pass_cnt++;
    // re-ARM while ARMED
    avl_write(3'd2, 32'd1);
    avl_write(3'd0, 32'h5);
    drive_sample(1'b0, 1'b1, AW'(0));
    drive_sample(1'b0, 1'b1, AW'(1));
    avl_write(3'd0, 32'h5);
    peek(3'd1, rd);
    total_cnt++;
    if (rd !== 32'h1) $display("FAIL rearm_state: got %0h, required 1", rd);
    else pass_cnt++;
    peek(3'd5, rd);
    total_cnt++;
    if (rd !== 32'd0) $display("FAIL rearm_wr_addr: got %0d, required 0", rd);
    else pass_cnt++;
    drive_sample(1'b0, 1'b1, AW'(0));
    avl_write(3'd0, 32'h6);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL abort_sb: %0d writes missing, required 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_done_race;
    avl_write(3'd2, 32'd0);
    avl_write(3'd3, 32'd1);
    avl_write(3'd0, 32'h5);
    drive_sample(1'b1, 1'b1, AW'(0));
    // last sample and W1C in the same cycle
    @(negedge clk);
    exp_q.push_back(AW'(1));
    sample_en = 1'b1; address = 3'd1; writedata = 32'h8; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    sample_en = 1'b0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    #1;
    total_cnt++;
    if (readdata !== 32'hC) $display("FAIL race_set_wins: got %0h, required c", readdata);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL race_irq_n1: got %0b, required 0", irq);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL race_irq_n2: got %0b, required 1", irq);
    else pass_cnt++;
    // W1C one cycle after completion
    avl_write(3'd0, 32'h5);
    drive_sample(1'b1, 1'b1, AW'(0));
    @(negedge clk);
    exp_q.push_back(AW'(1));
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0; address = 3'd1; writedata = 32'h8; chipselect = 1'b1; write_n = 1'b0;
    #1;
    total_cnt++;
    if (readdata !== 32'hC) $display("FAIL clr_before: got %0h, required c", readdata);
    else pass_cnt++;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    #1;
    total_cnt++;
    if (readdata !== 32'h4) $display("FAIL clr_after: got %0h, required 4", readdata);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL clr_irq_n2: got %0b, required 1", irq);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL clr_irq_drop: got %0b, required 0", irq);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL race_sb: %0d writes missing, required 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    avl_write(3'd2, 32'd0);
    avl_write(3'd3, 32'd3);
    avl_write(3'd0, 32'h5);
    drive_sample(1'b1, 1'b1, AW'(0));
    @(negedge clk);
    reset = 1'b1; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0; reset = 1'b0;
    peek(3'd1, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL midrst_status: got %0h, required 0", rd);
    else pass_cnt++;
    peek(3'd5, rd);
    total_cnt++;
    if (rd !== 32'd0) $display("FAIL midrst_wr_addr: got %0d, required 0", rd);
    else pass_cnt++;
    peek(3'd0, rd);
    total_cnt++;
    if (rd !== 32'd0) $display("FAIL midrst_ctrl: got %0h, required 0", rd);
    else pass_cnt++;
    repeat (2) drive_sample(1'b1, 1'b0, '0);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL midrst_sb: %0d writes missing, required 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; sample_en = 1'b0; trig_in = 1'b0;
    test_reset();
    test_full_capture();
    test_zero_counts();
    test_wrap();
    test_abort_priority();
    test_done_race();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
